phase_interval_timer: RTL and testbench

- Upstream timebase for the traffic light controller.
- Divides clk into a 1-second tick and counts elapsed seconds in the current phase.
- Decodes the count into the four threshold flags the controller consumes: count_eq30, count_eq90, count_eq100 and count_g_100.
- Accepts the controller's clear output to restart the interval, and supports run, pause and stop control.

---
 rtl/phase_interval_timer.sv | 138 +++++++++++++
 tb/tb_phase_interval_timer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_interval_timer.sv
// Seconds timebase for the traffic light controller: prescaler, saturating seconds count, threshold flags.
// Optional runtime-programmable thresholds are enabled with `define PHASE_TIMER_PROG_EN.
module phase_interval_timer #(
    parameter int unsigned TICKS_PER_SEC = 1000,
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned T_GREEN       = 30,
    parameter int unsigned T_YELLOW      = 90,
    parameter int unsigned T_RED_END     = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             hold,
    input  logic             clear,
`ifdef PHASE_TIMER_PROG_EN
    input  logic             cfg_we,
    input  logic [1:0]       cfg_sel,
    input  logic [CNT_W-1:0] cfg_data,
    output logic             cfg_err,
`endif
    output logic [CNT_W-1:0] count,
    output logic             tick_1s,
    output logic             count_eq30,
    output logic             count_eq90,
    output logic             count_eq100,
    output logic             count_g_100,
    output logic             running
);

    localparam int unsigned     PW         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    localparam logic [1:0] ST_STOP  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             tick_q, tick_d;
    logic             running_q;

    logic [CNT_W-1:0] thr_green, thr_yellow, thr_red;

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        count_d = count_q;
        tick_d  = 1'b0;
        if (!enable) begin
            state_d = ST_STOP;
            presc_d = '0;
            count_d = '0;
        end else if (state_q != ST_RUN && state_q != ST_PAUSE) begin
            // STOP (and any unreachable encoding) leaves via hold selection
            state_d = hold ? ST_PAUSE : ST_RUN;
        end else if (clear) begin
            presc_d = '0;
            count_d = '0;
        end else begin
            if (state_q == ST_RUN) begin
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                    if (count_q != CNT_MAX) begin
                        count_d = count_q + 1'b1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            state_d = hold ? ST_PAUSE : ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_STOP;
            presc_q   <= '0;
            count_q   <= '0;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            count_q   <= count_d;
            tick_q    <= tick_d;
            running_q <= (state_d == ST_RUN);
        end
    end

`ifdef PHASE_TIMER_PROG_EN
    logic [CNT_W-1:0] thr_green_q, thr_yellow_q, thr_red_q;
    logic             cfg_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            thr_green_q  <= CNT_W'(T_GREEN);
            thr_yellow_q <= CNT_W'(T_YELLOW);
            thr_red_q    <= CNT_W'(T_RED_END);
            cfg_err_q    <= 1'b0;
        end else begin
            cfg_err_q <= 1'b0;
            if (cfg_we) begin
                if (state_q != ST_STOP || cfg_sel == 2'd3) begin
                    cfg_err_q <= 1'b1;
                end else begin
                    case (cfg_sel)
                        2'd0:    thr_green_q  <= cfg_data;
                        2'd1:    thr_yellow_q <= cfg_data;
                        default: thr_red_q    <= cfg_data;
                    endcase
                end
            end
        end
    end

    assign thr_green  = thr_green_q;
    assign thr_yellow = thr_yellow_q;
    assign thr_red    = thr_red_q;
    assign cfg_err    = cfg_err_q;
`else
    assign thr_green  = CNT_W'(T_GREEN);
    assign thr_yellow = CNT_W'(T_YELLOW);
    assign thr_red    = CNT_W'(T_RED_END);
`endif

    // Flags decode only the count register so clear can be formed from them without a loop
    assign count       = count_q;
    assign tick_1s     = tick_q;
    assign running     = running_q;
    assign count_eq30  = (count_q == thr_green);
    assign count_eq90  = (count_q == thr_yellow);
    assign count_eq100 = (count_q == thr_red);
    assign count_g_100 = (count_q > thr_red);

endmodule

// File: tb/tb_phase_interval_timer.sv
// Directed self-checking bench for phase_interval_timer with TICKS_PER_SEC=4, CNT_W=8.
module tb_phase_interval_timer;

    logic       clk = 1'b0;
    logic       reset, enable, hold, clear;
    logic [7:0] count;
    logic       tick_1s, count_eq30, count_eq90, count_eq100, count_g_100, running;
`ifdef PHASE_TIMER_PROG_EN
    logic       cfg_we, cfg_err;
    logic [1:0] cfg_sel;
    logic [7:0] cfg_data;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    phase_interval_timer #(
        .TICKS_PER_SEC(4),
        .CNT_W        (8),
        .T_GREEN      (30),
        .T_YELLOW     (90),
        .T_RED_END    (100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .hold       (hold),
        .clear      (clear),
`ifdef PHASE_TIMER_PROG_EN
        .cfg_we     (cfg_we),
        .cfg_sel    (cfg_sel),
        .cfg_data   (cfg_data),
        .cfg_err    (cfg_err),
`endif
        .count      (count),
        .tick_1s    (tick_1s),
        .count_eq30 (count_eq30),
        .count_eq90 (count_eq90),
        .count_eq100(count_eq100),
        .count_g_100(count_g_100),
        .running    (running)
    );

    // flags packed as {eq30, eq90, eq100, g100}
    function automatic logic [3:0] flags();
        return {count_eq30, count_eq90, count_eq100, count_g_100};
    endfunction

    // Inputs change and outputs are sampled on the falling edge.
    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b0; hold = 1'b0; clear = 1'b0;
        edges(3);
        checks++;
        if ({count, tick_1s, running, flags()} !== 14'd0) begin
            failures++;
            $display("FAIL reset_state got cnt=%0d tick=%b run=%b flags=%b want all zero",
                     count, tick_1s, running, flags());
        end
        reset = 1'b1;
        edges(2);
        checks++;
        if ({count, running} !== 9'd0) begin
            failures++;
            $display("FAIL stop_idle got cnt=%0d run=%b want 0/0", count, running);
        end
    endtask

    task automatic test_count();
        enable = 1'b1;
        edges(1);                                   // edge 0
        checks++;
        if ({running, count} !== {1'b1, 8'd0}) begin
            failures++; $display("FAIL enter_run got run=%b cnt=%0d want 1/0", running, count);
        end
        edges(3);                                   // edge 3
        checks++;
        if ({count, tick_1s} !== {8'd0, 1'b0}) begin
            failures++; $display("FAIL pre_first_tick got cnt=%0d tick=%b want 0/0", count, tick_1s);
        end
        edges(1);                                   // edge 4
        checks++;
        if ({count, tick_1s} !== {8'd1, 1'b1}) begin
            failures++; $display("FAIL first_tick got cnt=%0d tick=%b want 1/1", count, tick_1s);
        end
        edges(1);                                   // edge 5
        checks++;
        if (tick_1s !== 1'b0) begin
            failures++; $display("FAIL tick_one_cycle got tick=%b want 0", tick_1s);
        end
        edges(115);                                 // edge 120
        checks++;
        if ({count, flags()} !== {8'd30, 4'b1000}) begin
            failures++; $display("FAIL eq30 got cnt=%0d flags=%b want 30/1000", count, flags());
        end
        edges(3);                                   // edge 123
        checks++;
        if ({count, flags()} !== {8'd30, 4'b1000}) begin
            failures++; $display("FAIL eq30_hold got cnt=%0d flags=%b want 30/1000", count, flags());
        end
        edges(1);                                   // edge 124
        checks++;
        if ({count, flags()} !== {8'd31, 4'b0000}) begin
            failures++; $display("FAIL eq30_drop got cnt=%0d flags=%b want 31/0000", count, flags());
        end
        edges(236);                                 // edge 360
        checks++;
        if ({count, flags()} !== {8'd90, 4'b0100}) begin
            failures++; $display("FAIL eq90 got cnt=%0d flags=%b want 90/0100", count, flags());
        end
        edges(40);                                  // edge 400
        checks++;
        if ({count, flags()} !== {8'd100, 4'b0010}) begin
            failures++; $display("FAIL eq100 got cnt=%0d flags=%b want 100/0010", count, flags());
        end
        edges(4);                                   // edge 404
        checks++;
        if ({count, flags()} !== {8'd101, 4'b0001}) begin
            failures++; $display("FAIL g100 got cnt=%0d flags=%b want 101/0001", count, flags());
        end
    endtask

    task automatic test_clear();
        clear = 1'b1;
        edges(1);
        clear = 1'b0;
        checks++;
        if ({count, flags(), tick_1s, running} !== {8'd0, 4'b0000, 1'b0, 1'b1}) begin
            failures++; $display("FAIL clear_zero got cnt=%0d flags=%b tick=%b run=%b want 0/0000/0/1",
                                 count, flags(), tick_1s, running);
        end
        edges(3);
        checks++;
        if (count !== 8'd0) begin
            failures++; $display("FAIL clear_restart_early got cnt=%0d want 0", count);
        end
        edges(1);
        checks++;
        if ({count, tick_1s} !== {8'd1, 1'b1}) begin
            failures++; $display("FAIL clear_restart got cnt=%0d tick=%b want 1/1", count, tick_1s);
        end
        // clear on the wrap edge suppresses both increment and tick
        edges(3);
        clear = 1'b1;
        edges(1);
        clear = 1'b0;
        checks++;
        if ({count, tick_1s} !== {8'd0, 1'b0}) begin
            failures++; $display("FAIL clear_on_wrap got cnt=%0d tick=%b want 0/0", count, tick_1s);
        end
    endtask

    task automatic test_hold();
        edges(180);                                 // count 45, prescaler 0
        edges(2);                                   // prescaler 2
        checks++;
        if (count !== 8'd45) begin
            failures++; $display("FAIL hold_setup got cnt=%0d want 45", count);
        end
        hold = 1'b1;
        edges(10);
        checks++;
        if ({count, running, tick_1s} !== {8'd45, 1'b0, 1'b0}) begin
            failures++; $display("FAIL hold_frozen got cnt=%0d run=%b tick=%b want 45/0/0",
                                 count, running, tick_1s);
        end
        hold = 1'b0;
        edges(1);
        checks++;
        if ({count, running} !== {8'd45, 1'b1}) begin
            failures++; $display("FAIL hold_resume got cnt=%0d run=%b want 45/1", count, running);
        end
        edges(1);
        checks++;
        if ({count, tick_1s} !== {8'd46, 1'b1}) begin
            failures++; $display("FAIL hold_release_tick got cnt=%0d tick=%b want 46/1", count, tick_1s);
        end
    endtask

    task automatic test_clear_hold_stop();
        edges(56);                                  // count 60
        hold = 1'b1;
        edges(1);
        clear = 1'b1;
        edges(1);
        clear = 1'b0;
        checks++;
        if ({count, running} !== {8'd0, 1'b0}) begin
            failures++; $display("FAIL clear_in_pause got cnt=%0d run=%b want 0/0", count, running);
        end
        edges(2);
        checks++;
        if ({count, running} !== {8'd0, 1'b0}) begin
            failures++; $display("FAIL pause_stays got cnt=%0d run=%b want 0/0", count, running);
        end
        hold = 1'b0;
        edges(9);                                   // resume edge + 8 -> count 2
        checks++;
        if (count !== 8'd2) begin
            failures++; $display("FAIL after_pause got cnt=%0d want 2", count);
        end
        enable = 1'b0; clear = 1'b1;
        edges(1);
        clear = 1'b0;
        checks++;
        if ({count, running} !== {8'd0, 1'b0}) begin
            failures++; $display("FAIL disable_stop got cnt=%0d run=%b want 0/0", count, running);
        end
        // clear in STOP is inert; STOP then goes to PAUSE with hold
        clear = 1'b1;
        edges(2);
        clear = 1'b0; enable = 1'b1; hold = 1'b1;
        edges(1);
        checks++;
        if ({count, running} !== {8'd0, 1'b0}) begin
            failures++; $display("FAIL stop_to_pause got cnt=%0d run=%b want 0/0", count, running);
        end
        hold = 1'b0;
        edges(1);
        checks++;
        if (running !== 1'b1) begin
            failures++; $display("FAIL pause_to_run got run=%b want 1", running);
        end
        enable = 1'b0;
        edges(1);
    endtask

    task automatic test_saturate();
        enable = 1'b1;
        edges(1);                                   // edge 0
        edges(1016);
        checks++;
        if (count !== 8'd254) begin
            failures++; $display("FAIL sat_pre got cnt=%0d want 254", count);
        end
        edges(4);
        checks++;
        if ({count, tick_1s, count_g_100} !== {8'd255, 1'b1, 1'b1}) begin
            failures++; $display("FAIL sat_reach got cnt=%0d tick=%b g100=%b want 255/1/1",
                                 count, tick_1s, count_g_100);
        end
        for (int i = 0; i < 45; i++) begin
            edges(1);
            checks++;
            if (tick_1s !== 1'b0) begin
                failures++; $display("FAIL sat_tick_low got tick=%b want 0", tick_1s);
            end
            edges(3);
            checks++;
            if ({count, tick_1s, count_g_100} !== {8'd255, 1'b1, 1'b1}) begin
                failures++; $display("FAIL sat_hold got cnt=%0d tick=%b g100=%b want 255/1/1",
                                     count, tick_1s, count_g_100);
            end
        end
    endtask

    task automatic test_async_reset();
        edges(3);                                   // next edge would pulse tick
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({count, tick_1s, running, flags()} !== 14'd0) begin
            failures++; $display("FAIL async_reset got cnt=%0d tick=%b run=%b flags=%b want all zero",
                                 count, tick_1s, running, flags());
        end
        edges(2);
        checks++;
        if ({count, tick_1s, running} !== 10'd0) begin
            failures++; $display("FAIL reset_held got cnt=%0d tick=%b run=%b want 0", count, tick_1s, running);
        end
        enable = 1'b0;
        reset = 1'b1;
        edges(1);
    endtask

`ifdef PHASE_TIMER_PROG_EN
    task automatic test_prog();
        cfg_we = 1'b1; cfg_sel = 2'd0; cfg_data = 8'd5;
        edges(1);
        cfg_we = 1'b0;
        checks++;
        if (cfg_err !== 1'b0) begin
            failures++; $display("FAIL cfg_stop_write got err=%b want 0", cfg_err);
        end
        cfg_we = 1'b1; cfg_sel = 2'd3;
        edges(1);
        cfg_we = 1'b0;
        checks++;
        if (cfg_err !== 1'b1) begin
            failures++; $display("FAIL cfg_sel3 got err=%b want 1", cfg_err);
        end
        enable = 1'b1;
        edges(21);                                  // edge 0 + 20 -> count 5
        checks++;
        if ({count, count_eq30} !== {8'd5, 1'b1}) begin
            failures++; $display("FAIL cfg_eq_new got cnt=%0d eq30=%b want 5/1", count, count_eq30);
        end
        cfg_we = 1'b1; cfg_sel = 2'd0; cfg_data = 8'd7;
        edges(1);
        cfg_we = 1'b0;
        checks++;
        if (cfg_err !== 1'b1) begin
            failures++; $display("FAIL cfg_run_err got err=%b want 1", cfg_err);
        end
        edges(1);
        checks++;
        if (cfg_err !== 1'b0) begin
            failures++; $display("FAIL cfg_err_pulse got err=%b want 0", cfg_err);
        end
        edges(6);                                   // count 7
        checks++;
        if ({count, count_eq30} !== {8'd7, 1'b0}) begin
            failures++; $display("FAIL cfg_run_ignored got cnt=%0d eq30=%b want 7/0", count, count_eq30);
        end
        enable = 1'b0;
        edges(1);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef PHASE_TIMER_PROG_EN
        cfg_we = 1'b0; cfg_sel = 2'd0; cfg_data = 8'd0;
`endif
        edges(1);
        test_reset();
        test_count();
        test_clear();
        test_hold();
        test_clear_hold_stop();
        test_saturate();
        test_async_reset();
`ifdef PHASE_TIMER_PROG_EN
        test_prog();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
